// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream program loader; writes a 256-byte core memory and holds the core in reset until the checksum passes
// ports: clk, rst (sync active-low) | in_valid/in_data/in_ready byte stream | reload (honoured in RUN only)
//        mem_addr/mem_wdata/mem_ena/mem_write memory write port | core_rst (active-low core reset), done (RUN), err (sticky csum fail)
module prog_loader #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       reload,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_ena,
  output logic       mem_write,
  output logic       core_rst,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, RUN} state_t;
  state_t state, state_nx;
  logic live;
  logic take;
  logic [7:0] ptr, acc, sum;
  logic [8:0] cnt;
  assign take = in_valid && in_ready;
  assign sum = acc + in_data;
  assign mem_ena = mem_write;
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (take && in_data == HEADER) ? ADDR : IDLE;
      ADDR: state_nx = take ? LEN : ADDR;
      LEN:  state_nx = take ? DATA : LEN;
      DATA: state_nx = (take && cnt == 9'd1) ? CSUM : DATA;
      CSUM: state_nx = take ? ((sum == 8'd0) ? RUN : IDLE) : CSUM;
      RUN:  state_nx = reload ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // live keeps in_ready low for the whole reset and the first cycle back
  always_comb begin
    in_ready = live && state != RUN;
    core_rst = state == RUN;
    done = state == RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      live <= 1'b0;
      ptr <= 8'd0;
      acc <= 8'd0;
      cnt <= 9'd0;
      mem_addr <= 8'd0;
      mem_wdata <= 8'd0;
      mem_write <= 1'b0;
      err <= 1'b0;
    end else begin
      live <= 1'b1;
      mem_write <= take && state == DATA;
      if (take) begin
        case (state)
          IDLE: if (in_data == HEADER) err <= 1'b0;
          ADDR: begin
            ptr <= in_data;
            acc <= in_data;
          end
          LEN: begin
            cnt <= {in_data == 8'd0, in_data};
            acc <= sum;
          end
          DATA: begin
            mem_addr <= ptr;
            mem_wdata <= in_data;
            ptr <= ptr + 8'd1;
            cnt <= cnt - 9'd1;
            acc <= sum;
          end
          CSUM: if (sum != 8'd0) err <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic reload = 1'b0;
  logic in_ready, mem_ena, mem_write, core_rst, done, err;
  logic [7:0] mem_addr, mem_wdata;
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic [7:0] pl[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ena(mem_ena),
    .mem_write(mem_write), .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        check("write {ena,addr,data}", {mem_ena, mem_addr, mem_wdata}, {1'b1, exp_w});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %0h", b);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] start, input logic [7:0] data[$], input logic [7:0] cs, input int gap);
    logic [7:0] len;
    len = 8'(data.size());
    send(8'hA5);
    check("err cleared by header", err, 0);
    idle(gap);
    send(start);
    idle(gap);
    send(len);
    for (int i = 0; i < data.size(); i++) begin
      exp_q.push_back({start + 8'(i), data[i]});
      send(data[i]);
      if (gap > 0 && i == 0) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        idle(gap - 1);
      end else idle(gap);
    end
    send(cs);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("after reload {core_rst,done,in_ready}", {core_rst, done, in_ready}, 3'b001);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle(3);
    check("reset outputs", {in_ready, mem_addr, mem_wdata, mem_ena, mem_write, core_rst, done, err}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready after reset {in_ready,core_rst,done}", {in_ready, core_rst, done}, 3'b100);

    pl = {8'h11, 8'h22, 8'h33};
    frame(8'h10, pl, 8'h87, 0);
    check("frame1 {core_rst,done,in_ready,err}", {core_rst, done, in_ready, err}, 4'b1100);
    check("frame1 writes drained", exp_q.size(), 0);
    do_reload();

    frame(8'h10, pl, 8'h90, 0);
    check("bad csum {core_rst,done,in_ready,err}", {core_rst, done, in_ready, err}, 4'b0011);
    check("bad csum writes drained", exp_q.size(), 0);
    idle(2);
    check("err sticky", err, 1);

    pl = {8'hAA, 8'hBB, 8'hCC};
    frame(8'hFE, pl, 8'hCE, 0);
    check("wrap {core_rst,done,err}", {core_rst, done, err}, 3'b110);
    check("wrap writes drained", exp_q.size(), 0);
    do_reload();

    send(8'h7E);
    send(8'h00);
    check("junk ignored {core_rst,done,err}", {core_rst, done, err}, 3'b000);
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    frame(8'h40, pl, 8'h40, 0);
    check("len0 {core_rst,done,err}", {core_rst, done, err}, 3'b110);
    check("len0 writes drained", exp_q.size(), 0);
    do_reload();

    pl = {8'h5A, 8'hC3};
    frame(8'h80, pl, 8'h61, 2);
    check("gapped {core_rst,done,err}", {core_rst, done, err}, 3'b110);
    check("gapped writes drained", exp_q.size(), 0);
    do_reload();

    send(8'hA5);
    send(8'h20);
    send(8'h05);
    exp_q.push_back({8'h20, 8'h01});
    send(8'h01);
    exp_q.push_back({8'h21, 8'h02});
    send(8'h02);
    rst = 1'b0;
    @(negedge clk);
    check("midframe reset outputs", {in_ready, mem_addr, mem_wdata, mem_ena, mem_write, core_rst, done, err}, 0);
    check("midframe writes drained", exp_q.size(), 0);
    rst = 1'b1;
    idle(2);
    check("after midframe reset {in_ready,done}", {in_ready, done}, 2'b10);
    pl = {8'h77, 8'h88};
    frame(8'h30, pl, 8'hCF, 0);
    check("post-reset frame {core_rst,done,err}", {core_rst, done, err}, 3'b110);

    idle(3);
    check("final queue empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
